// File: rtl/stdout_uart_tx_pkg.sv
// Shared constants, FSM states and status helpers for the stdout UART.
// Optional even parity bit is enabled by defining STDOUT_PARITY_EN.
package stdout_uart_tx_pkg;

  localparam logic [23:0] STATUS_ADDR_DEF = 24'hFFFFFD;
  localparam logic [23:0] STDOUT_ADDR_DEF = 24'hFFFFFE;
  localparam logic [23:0] HALT_ADDR_DEF   = 24'hFFFFFF;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_HALT  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  function automatic logic [31:0] status_word(
    input logic halt,
    input logic ovf,
    input logic busy,
    input logic full,
    input logic empty
  );
    logic [31:0] w;
    w           = '0;
    w[ST_HALT]  = halt;
    w[ST_OVF]   = ovf;
    w[ST_BUSY]  = busy;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    return w;
  endfunction

endpackage

// File: rtl/stdout_uart_tx_if.sv
// CPU data-bus slice seen by the stdout/halt peripheral.
// STDOUT_PARITY_EN does not change this interface.
interface stdout_uart_tx_if;
  logic [23:0] i_addr;
  logic        i_wr;
  logic        i_rd;
  logic [31:0] i_din;
  logic [31:0] o_dout;
  logic        o_sel;

  modport master (
    output i_addr, i_wr, i_rd, i_din,
    input  o_dout, o_sel
  );

  modport slave (
    input  i_addr, i_wr, i_rd, i_din,
    output o_dout, o_sel
  );
endinterface

// File: rtl/stdout_uart_tx_fifo.sv
// Byte FIFO with first-word-fall-through output for the UART.
// Independent of STDOUT_PARITY_EN.
module stdout_uart_tx_fifo #(
  parameter int AW = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]  mem_q [2**AW];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // A full FIFO still takes a byte when one leaves the same cycle
  assign do_push = en_i & push_i & (~full_o | pop_i);
  assign do_pop  = en_i & pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/stdout_uart_tx.sv
// Console TX / halt peripheral: bus decode, status, FIFO and UART FSM.
// Define STDOUT_PARITY_EN for an even parity bit (11-bit frames).
module stdout_uart_tx
  import stdout_uart_tx_pkg::*;
#(
  parameter int          CLK_DIV     = 16,
  parameter int          FIFO_AW     = 4,
  parameter logic [23:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [23:0] STDOUT_ADDR = STDOUT_ADDR_DEF,
  parameter logic [23:0] HALT_ADDR   = HALT_ADDR_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstb,
  input  logic             i_clk_en,
  stdout_uart_tx_if.slave  bus,
  output logic             o_txd,
  output logic             o_halt,
  output logic [7:0]       o_halt_code
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);

  tx_state_e   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        txd_q;
  logic [31:0] dout_q;
  logic        ovf_q;
  logic        halt_q;
  logic [7:0]  code_q;

  logic        hit_status;
  logic        hit_stdout;
  logic        hit_halt;
  logic        push;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  logic        baud_done;
  logic [7:0]  fifo_dout;
  logic [31:0] status_d;
  logic        unused_din;

  assign hit_status = (bus.i_addr == STATUS_ADDR);
  assign hit_stdout = (bus.i_addr == STDOUT_ADDR);
  assign hit_halt   = (bus.i_addr == HALT_ADDR);
  assign bus.o_sel  = hit_status | hit_stdout | hit_halt;
  assign bus.o_dout = dout_q;
  assign unused_din = ^bus.i_din[31:8];

  assign baud_done = (baud_q == '0);
  assign push      = bus.i_wr & hit_stdout;
  assign pop       = ~empty & ((state_q == S_IDLE) |
                     ((state_q == S_STOP) & baud_done));
  assign drop      = push & full & ~pop;
  assign status_d  = status_word(halt_q, ovf_q,
                       state_q != S_IDLE, full, empty);

  stdout_uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rstb),
    .en_i    (i_clk_en),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.i_din[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      halt_q <= 1'b0;
      code_q <= '0;
    end else if (i_clk_en) begin
      if (bus.i_rd) dout_q <= hit_status ? status_d : '0;
      // A drop in the same cycle as a status read keeps ovf set
      if (drop)
        ovf_q <= 1'b1;
      else if (bus.i_rd && hit_status)
        ovf_q <= 1'b0;
      if (bus.i_wr && hit_halt && !halt_q) begin
        halt_q <= 1'b1;
        code_q <= bus.i_din[7:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else if (i_clk_en) begin
      if (pop) begin
        state_q <= S_START;
        baud_q  <= RELOAD;
        sh_q    <= fifo_dout;
        txd_q   <= 1'b0;
      end else if (!baud_done) begin
        baud_q <= baud_q - 1'b1;
      end else begin
        case (state_q)
          S_START: begin
            state_q <= S_DATA;
            baud_q  <= RELOAD;
            bit_q   <= '0;
            txd_q   <= sh_q[0];
          end
          S_DATA: begin
            baud_q <= RELOAD;
            // Rotate so the full byte stays available for parity
            sh_q   <= {sh_q[0], sh_q[7:1]};
            if (bit_q != 3'd7) begin
              bit_q <= bit_q + 1'b1;
              txd_q <= sh_q[1];
            end else begin
`ifdef STDOUT_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= ^sh_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            baud_q  <= RELOAD;
            txd_q   <= 1'b1;
          end
          S_STOP:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_txd       = txd_q;
  assign o_halt      = halt_q;
  assign o_halt_code = code_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Scoreboard bench for stdout_uart_tx against a frame-level model.
// Honours STDOUT_PARITY_EN for the expected frame length.
module tb_stdout_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 16;
`ifdef STDOUT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam logic [23:0] A_ST  = 24'hFFFFFD;
  localparam logic [23:0] A_OUT = 24'hFFFFFE;
  localparam logic [23:0] A_HLT = 24'hFFFFFF;
  localparam logic [23:0] A_OTH = 24'h000100;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       clk_en = 1'b0;
  logic       txd;
  logic       halt;
  logic [7:0] code;

  stdout_uart_tx_if bus();

  stdout_uart_tx #(.CLK_DIV(D), .FIFO_AW(4)) dut (
    .i_clk       (clk),
    .i_rstb      (rstb),
    .i_clk_en    (clk_en),
    .bus         (bus),
    .o_txd       (txd),
    .o_halt      (halt),
    .o_halt_code (code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int en_idx = 0;

  always @(posedge clk) if (clk_en && rstb) en_idx <= en_idx + 1;

  typedef struct {
    logic [10:0] bits;
    int          idx;
  } frame_t;

  frame_t      txq[$];
  logic [31:0] rdq[$];

  logic [7:0] m_fifo[$];
  int         m_rem = 0;
  bit         m_ovf = 0;
  bit         m_halt = 0;
  logic [7:0] m_code = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    f[8:1] = b;
`ifdef STDOUT_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9] = 1'b1;
`endif
    return f;
  endfunction

  // One enabled edge of the reference: reads see pre-edge state
  task automatic model_step(bit wr, bit rd, logic [23:0] a, logic [31:0] d);
    logic [31:0] st;
    bit pop, full_pre, dropped;
    st = '0;
    st[0] = (m_fifo.size() == 0);
    st[1] = (m_fifo.size() == DEPTH);
    st[2] = (m_rem != 0);
    st[3] = m_ovf;
    st[4] = m_halt;
    if (rd) rdq.push_back(a == A_ST ? st : 32'h0);
    full_pre = (m_fifo.size() == DEPTH);
    pop = (m_fifo.size() != 0) && (m_rem <= 1);
    if (pop) begin
      frame_t f;
      f.bits = frame_bits(m_fifo.pop_front());
      f.idx  = en_idx + 1;
      txq.push_back(f);
      m_rem = NB * D;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    dropped = 0;
    if (wr && a == A_OUT) begin
      if (!full_pre || pop) m_fifo.push_back(d[7:0]);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (rd && a == A_ST) m_ovf = 0;
    if (wr && a == A_HLT && !m_halt) begin
      m_halt = 1;
      m_code = d[7:0];
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    txq.delete();
    m_rem  = 0;
    m_ovf  = 0;
    m_halt = 0;
    m_code = '0;
  endtask

  task automatic cyc(bit wr, bit rd, logic [23:0] a, logic [31:0] d, bit en);
    bus.i_wr   = wr;
    bus.i_rd   = rd;
    bus.i_addr = a;
    bus.i_din  = d;
    clk_en     = en;
    #1;
    if (wr || rd)
      check("sel", {31'b0, bus.o_sel},
            {31'b0, (a == A_ST) || (a == A_OUT) || (a == A_HLT)});
    if (en && rstb) model_step(wr, rd, a, d);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, A_OTH, 32'h0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_fifo.size() != 0 || m_rem != 0) && n < 3000) begin
      cyc(0, 0, A_OTH, 32'h0, 1);
      n++;
    end
    idle(3);
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL drain_timeout: got %0d cycles limit 3000", n);
    end
  endtask

  // Monitor: read data and serial frames, sampled after each edge
  logic [10:0] obs;
  int          mpos = 0;
  bit          mact = 0;
  int          mstart = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rstb) begin
        mact = 0;
      end else if (clk_en) begin
        if (bus.i_rd) begin
          if (rdq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got %h expected none", bus.o_dout);
          end else begin
            check("rd_data", bus.o_dout, rdq.pop_front());
          end
        end
        if (!mact && txd === 1'b0) begin
          mact   = 1;
          mpos   = 0;
          obs    = '0;
          mstart = en_idx;
        end
        if (mact) begin
          int slot;
          slot = mpos / D;
          if (mpos % D == 0) obs[slot] = txd;
          else if (obs[slot] !== txd) obs[slot] = 1'bx;
          mpos++;
          if (mpos == NB * D) begin
            mact = 0;
            if (txq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_unexpected: got %h expected none", obs);
            end else begin
              frame_t f;
              f = txq.pop_front();
              check("frame_bits", {21'b0, obs}, {21'b0, f.bits});
              check("frame_start", mstart, f.idx);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_wr   = 0;
    bus.i_rd   = 0;
    bus.i_addr = A_OTH;
    bus.i_din  = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_code", {24'b0, code}, 32'h0);
    check("rst_dout", bus.o_dout, 32'h0);
    rstb = 1;

    cyc(0, 1, A_ST, 32'h0, 1);
    cyc(0, 1, A_OTH, 32'h0, 1);

    // Single byte 'A'
    cyc(1, 0, A_OUT, 32'hFFFF_FF41, 1);
    drain();

    // Overflow: one frame running, then 17 back-to-back stores
    cyc(1, 0, A_OUT, 32'h30, 1);
    idle(2);
    for (int i = 0; i < 17; i++) cyc(1, 0, A_OUT, $urandom, 1);
    cyc(0, 1, A_ST, 32'h0, 1);
    cyc(0, 1, A_ST, 32'h0, 1);

    // Halt is sticky with the first code
    cyc(1, 0, A_HLT, 32'h0000_0003, 1);
    cyc(1, 0, A_HLT, 32'h0000_0007, 1);
    check("halt", {31'b0, halt}, {31'b0, m_halt});
    check("halt_code", {24'b0, code}, {24'b0, m_code});
    drain();

    // Clock enable toggling mid-frame
    cyc(1, 0, A_OUT, 32'hC5, 1);
    for (int i = 0; i < 2 * NB * D + 10; i++)
      cyc(0, i % 3 == 0, A_ST, 32'h0, i % 2 == 0);
    drain();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [23:0] a;
      case ($urandom_range(0, 3))
        0: a = A_ST;
        1: a = A_OUT;
        2: a = A_HLT;
        default: a = 24'($urandom);
      endcase
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
          a, $urandom, $urandom_range(0, 3) != 0);
    end
    drain();
    cyc(0, 1, A_ST, 32'h0, 1);

    // Async reset during a data bit of a zero byte
    cyc(1, 0, A_OUT, 32'h00, 1);
    idle(D + 6);
    #2;
    rstb = 0;
    #1;
    check("rst_mid_txd", {31'b0, txd}, 32'h1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstb = 1;
    cyc(0, 1, A_ST, 32'h0, 1);
    check("rst_mid_halt", {31'b0, halt}, {31'b0, m_halt});
    cyc(1, 0, A_OUT, 32'h5A, 1);
    drain();

    check("txq_left", txq.size(), 32'h0);
    check("rdq_left", rdq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
